execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
Execute stage of the 5-stage pipelined core. It sits directly downstream of the decode stage and consumes its E-stage register outputs. It selects forwarded operands and runs the ALU. It resolves branches and computes the branch target, then registers the results into the E/M pipeline register that feeds the memory stage. Forwarding selects come from the hazard unit.

Parameters:
WIDTH, 32, datapath width (operands, PC, immediates).
RADDR_W, 5, register-address width carried down the pipeline.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
RegWriteE  input  1  register-write enable from decode.
ALUSrcE  input  1  0: SrcB = forwarded RD2; 1: SrcB = Imm_Ext_E.
MemWriteE  input  1  memory-write enable.
ResultSrcE  input  1  0: ALU result; 1: memory read data (used in W).
BranchE  input  1  instruction is a branch (beq semantics).
ALUControlE  input  3  ALU operation select.
RD1_E  input  WIDTH  register operand A from decode.
RD2_E  input  WIDTH  register operand B from decode.
Imm_Ext_E  input  WIDTH  sign-extended immediate.
RD_E  input  RADDR_W  destination register.
PCE  input  WIDTH  PC of the instruction.
PCPlus4E  input  WIDTH  PC+4.
ForwardAE  input  2  operand A source select.
ForwardBE  input  2  operand B source select.
ResultW  input  WIDTH  writeback result for forwarding.
PCSrcE  output  1  branch taken; redirects fetch (combinational).
PCTargetE  output  WIDTH  branch target (combinational).
RegWriteM  output  1  registered RegWriteE.
MemWriteM  output  1  registered MemWriteE.
ResultSrcM  output  1  registered ResultSrcE.
RD_M  output  RADDR_W  registered RD_E.
ALUResultM  output  WIDTH  registered ALU result.
WriteDataM  output  WIDTH  registered forwarded operand B (store data).
PCPlus4M  output  WIDTH  registered PCPlus4E.

Behaviour:
- Forward mux A: 00 → RD1_E, 01 → ResultW, 10 → ALUResultM (this block's own registered output), 11 → RD1_E. Mux B is identical, using RD2_E.
- SrcAE = forwarded A.
- SrcBE = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteDataE = forwarded B, regardless of ALUSrcE.
- ALU ops by ALUControlE:
  - 000: add
  - 001: sub (A−B)
  - 010: and
  - 011: or
  - 100: xor
  - 101: sll, shift amount SrcB[4:0]
  - 110: srl (logical), shift amount SrcB[4:0]
  - 111: slt (signed A<B → 1, else 0, zero-extended)
- Add, sub and PC arithmetic wrap modulo 2^WIDTH; there is no overflow output. A shift amount ≥ WIDTH cannot occur because only 5 bits are used.
- ZeroE = (ALU result == 0). PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + Imm_Ext_E, computed every cycle whether or not the instruction is a branch.
- PCSrcE and PCTargetE are combinational: same-cycle response, no latency.
- E/M register: all M outputs update on the rising clk edge, 1-cycle latency from the E inputs.
- Reset: when rst=1 at a rising edge, the following clear to 0 and take precedence over new data:
  - RegWriteM, MemWriteM, ResultSrcM
  - RD_M, ALUResultM, WriteDataM, PCPlus4M
- Reset mid-operation discards the in-flight E instruction. No write is issued in M in the cycle following reset.
- Combinational outputs keep following the inputs during reset. The hazard/fetch logic gates them with rst.
- Forward select 10 during the first cycle after reset yields 0, the reset value of ALUResultM.
- A taken branch does not by itself suppress the E/M register. The branch instruction flows into M with RegWriteM/MemWriteM as decoded (0 for branches). Flushing of younger instructions is done upstream.
- No stall input: the register loads every non-reset cycle.

Test Plan:
- Reset: drive rst=1 with non-zero inputs for 2 cycles → all M outputs 0. Release rst → next edge captures the inputs.
- Add/imm: RD1_E=0x0000_0005, Imm_Ext_E=0xFFFF_FFFD, ALUSrcE=1, ALUControlE=000, RD_E=3, RegWriteE=1 → one cycle later ALUResultM=0x0000_0002, RD_M=3, RegWriteM=1.
- Forwarding: cycle n computes 10+20 → ALUResultM=30. Cycle n+1: ForwardAE=10, RD1_E=0, Imm=1, ALUSrcE=1, add → ALUResultM=31. Repeat with ForwardBE=01, ResultW=0x55, sub with A=0x60 → 0x0B.
- Branch: BranchE=1, sub, A=B=0x1234, PCE=0x100, Imm=0xFFFF_FFF0 → PCSrcE=1, PCTargetE=0xF0 same cycle. Change B to 0x1235 → PCSrcE=0.
- Shifts/slt:
  - sll of 1 by SrcB=0x21 → 0x2.
  - srl of 0x8000_0000 by 31 → 1.
  - slt with A=0xFFFF_FFFF, B=1 → 1; with A=1, B=0xFFFF_FFFF → 0.
- Store data: MemWriteE=1, ALUSrcE=1, ForwardBE=01, ResultW=0xDEAD_BEEF → WriteDataM=0xDEAD_BEEF, MemWriteM=1, ALUResultM=base+imm.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the E/M pipeline register.
// Branch outcome and target are combinational; everything bound for M is registered.
module execute_stage #(
   parameter int WIDTH   = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               RegWriteE,
   input  logic               ALUSrcE,
   input  logic               MemWriteE,
   input  logic               ResultSrcE,
   input  logic               BranchE,
   input  logic [2:0]         ALUControlE,
   input  logic [WIDTH-1:0]   RD1_E,
   input  logic [WIDTH-1:0]   RD2_E,
   input  logic [WIDTH-1:0]   Imm_Ext_E,
   input  logic [RADDR_W-1:0] RD_E,
   input  logic [WIDTH-1:0]   PCE,
   input  logic [WIDTH-1:0]   PCPlus4E,
   input  logic [1:0]         ForwardAE,
   input  logic [1:0]         ForwardBE,
   input  logic [WIDTH-1:0]   ResultW,
   output logic               PCSrcE,
   output logic [WIDTH-1:0]   PCTargetE,
   output logic               RegWriteM,
   output logic               MemWriteM,
   output logic               ResultSrcM,
   output logic [RADDR_W-1:0] RD_M,
   output logic [WIDTH-1:0]   ALUResultM,
   output logic [WIDTH-1:0]   WriteDataM,
   output logic [WIDTH-1:0]   PCPlus4M
);

   logic               r_reg_write_m;
   logic               r_mem_write_m;
   logic               r_result_src_m;
   logic [RADDR_W-1:0] r_rd_m;
   logic [WIDTH-1:0]   r_alu_result_m;
   logic [WIDTH-1:0]   r_write_data_m;
   logic [WIDTH-1:0]   r_pc_plus4_m;

   logic [WIDTH-1:0]   w_src_a;
   logic [WIDTH-1:0]   w_fwd_b;
   logic [WIDTH-1:0]   w_src_b;
   logic [WIDTH-1:0]   w_alu_result;
   logic               w_slt;
   logic               w_zero;

   // Operand A forwarding: 10 takes our own registered result (EX->EX bypass).
   always_comb begin
      w_src_a = RD1_E;
      case (ForwardAE)
         2'b00:   w_src_a = RD1_E;
         2'b01:   w_src_a = ResultW;
         2'b10:   w_src_a = r_alu_result_m;
         default: w_src_a = RD1_E;
      endcase
   end

   // Operand B forwarding; the forwarded value is also the store data.
   always_comb begin
      w_fwd_b = RD2_E;
      case (ForwardBE)
         2'b00:   w_fwd_b = RD2_E;
         2'b01:   w_fwd_b = ResultW;
         2'b10:   w_fwd_b = r_alu_result_m;
         default: w_fwd_b = RD2_E;
      endcase
   end

   // ALU source B select between forwarded register and immediate.
   always_comb begin
      w_src_b = w_fwd_b;
      if (ALUSrcE) begin
         w_src_b = Imm_Ext_E;
      end else begin
         w_src_b = w_fwd_b;
      end
   end

   assign w_slt = ($signed(w_src_a) < $signed(w_src_b));

   // ALU operation decode; shifts only ever use the low five bits of B.
   always_comb begin
      w_alu_result = {WIDTH{1'b0}};
      case (ALUControlE)
         3'b000:  w_alu_result = w_src_a + w_src_b;
         3'b001:  w_alu_result = w_src_a - w_src_b;
         3'b010:  w_alu_result = w_src_a & w_src_b;
         3'b011:  w_alu_result = w_src_a | w_src_b;
         3'b100:  w_alu_result = w_src_a ^ w_src_b;
         3'b101:  w_alu_result = w_src_a << w_src_b[4:0];
         3'b110:  w_alu_result = w_src_a >> w_src_b[4:0];
         3'b111:  w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
         default: w_alu_result = {WIDTH{1'b0}};
      endcase
   end

   assign w_zero    = (w_alu_result == {WIDTH{1'b0}});
   assign PCSrcE    = BranchE & w_zero;
   assign PCTargetE = PCE + Imm_Ext_E;

   // E/M pipeline register; reset drops the in-flight instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_write_m  <= 1'b0;
         r_mem_write_m  <= 1'b0;
         r_result_src_m <= 1'b0;
         r_rd_m         <= {RADDR_W{1'b0}};
         r_alu_result_m <= {WIDTH{1'b0}};
         r_write_data_m <= {WIDTH{1'b0}};
         r_pc_plus4_m   <= {WIDTH{1'b0}};
      end else begin
         r_reg_write_m  <= RegWriteE;
         r_mem_write_m  <= MemWriteE;
         r_result_src_m <= ResultSrcE;
         r_rd_m         <= RD_E;
         r_alu_result_m <= w_alu_result;
         r_write_data_m <= w_fwd_b;
         r_pc_plus4_m   <= PCPlus4E;
      end
   end

   assign RegWriteM  = r_reg_write_m;
   assign MemWriteM  = r_mem_write_m;
   assign ResultSrcM = r_result_src_m;
   assign RD_M       = r_rd_m;
   assign ALUResultM = r_alu_result_m;
   assign WriteDataM = r_write_data_m;
   assign PCPlus4M   = r_pc_plus4_m;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the execute stage.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

   int checks   = 0;
   int failures = 0;

   // Model of the M-stage state.
   logic        exp_rw, exp_mw, exp_rs;
   logic [4:0]  exp_rd;
   logic [31:0] exp_alu, exp_wd, exp_pc4;

   execute_stage #(.WIDTH(32), .RADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << (b % 32);
         3'd6:    return a >> (b % 32);
         default: return (sa < sb) ? 32'd1 : 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val);
      if (sel == 2'd1) return ResultW;
      if (sel == 2'd2) return exp_alu;
      return reg_val;
   endfunction

   task automatic clear_inputs();
      RegWriteE = 1'b0; ALUSrcE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0;
      BranchE = 1'b0; ALUControlE = 3'd0; RD1_E = 32'd0; RD2_E = 32'd0;
      Imm_Ext_E = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0; RD_E = 5'd0;
      ForwardAE = 2'd0; ForwardBE = 2'd0; ResultW = 32'd0;
   endtask

   // Inputs are already applied; check combinational outputs, clock once, check M outputs.
   task automatic run_cycle();
      logic [31:0] a, fb, b, res;
      #1;
      a   = pick(ForwardAE, RD1_E);
      fb  = pick(ForwardBE, RD2_E);
      b   = ALUSrcE ? Imm_Ext_E : fb;
      res = ref_alu(ALUControlE, a, b);
      check_val("pcsrc", {31'd0, PCSrcE}, {31'd0, (BranchE && res == 32'd0)});
      check_val("pctarget", PCTargetE, PCE + Imm_Ext_E);
      @(posedge clk);
      if (rst) begin
         exp_rw = 1'b0; exp_mw = 1'b0; exp_rs = 1'b0; exp_rd = 5'd0;
         exp_alu = 32'd0; exp_wd = 32'd0; exp_pc4 = 32'd0;
      end else begin
         exp_rw = RegWriteE; exp_mw = MemWriteE; exp_rs = ResultSrcE; exp_rd = RD_E;
         exp_alu = res; exp_wd = fb; exp_pc4 = PCPlus4E;
      end
      #1;
      check_val("regwrite_m", {31'd0, RegWriteM}, {31'd0, exp_rw});
      check_val("memwrite_m", {31'd0, MemWriteM}, {31'd0, exp_mw});
      check_val("resultsrc_m", {31'd0, ResultSrcM}, {31'd0, exp_rs});
      check_val("rd_m", {27'd0, RD_M}, {27'd0, exp_rd});
      check_val("aluresult_m", ALUResultM, exp_alu);
      check_val("writedata_m", WriteDataM, exp_wd);
      check_val("pcplus4_m", PCPlus4M, exp_pc4);
   endtask

   initial begin
      exp_alu = 32'd0;
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;

      // Reset held with busy inputs for two cycles.
      RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd9;
      RD1_E = 32'h1111_0000; RD2_E = 32'h2222_0000; PCPlus4E = 32'h44;
      run_cycle();
      run_cycle();
      check_val("reset_alu_zero", ALUResultM, 32'd0);

      // First cycle after reset: EX bypass sees the reset value 0.
      rst = 1'b0;
      clear_inputs();
      ForwardAE = 2'd2; ALUSrcE = 1'b1; Imm_Ext_E = 32'd7; RD1_E = 32'h99;
      run_cycle();
      check_val("fwd_after_reset", ALUResultM, 32'd7);

      // addi 5 + (-3)
      clear_inputs();
      RD1_E = 32'd5; Imm_Ext_E = 32'hFFFF_FFFD; ALUSrcE = 1'b1; RD_E = 5'd3; RegWriteE = 1'b1;
      run_cycle();
      check_val("addi", ALUResultM, 32'h2);

      // 10 + 20, then bypass the 30 and add 1.
      clear_inputs();
      RD1_E = 32'd10; RD2_E = 32'd20;
      run_cycle();
      clear_inputs();
      ForwardAE = 2'd2; ALUSrcE = 1'b1; Imm_Ext_E = 32'd1;
      run_cycle();
      check_val("fwd_ex", ALUResultM, 32'd31);

      // sub 0x60 - ResultW(0x55)
      clear_inputs();
      RD1_E = 32'h60; ForwardBE = 2'd1; ResultW = 32'h55; ALUControlE = 3'd1;
      run_cycle();
      check_val("fwd_wb_sub", ALUResultM, 32'h0B);

      // Branch equal, then not equal.
      clear_inputs();
      BranchE = 1'b1; ALUControlE = 3'd1; RD1_E = 32'h1234; RD2_E = 32'h1234;
      PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF0;
      #1;
      check_val("beq_taken", {31'd0, PCSrcE}, 32'd1);
      check_val("beq_target", PCTargetE, 32'hF0);
      run_cycle();
      RD2_E = 32'h1235;
      #1;
      check_val("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
      run_cycle();

      // Shifts and slt corner cases.
      clear_inputs();
      ALUControlE = 3'd5; RD1_E = 32'd1; RD2_E = 32'h21;
      run_cycle();
      check_val("sll", ALUResultM, 32'h2);
      ALUControlE = 3'd6; RD1_E = 32'h8000_0000; RD2_E = 32'd31;
      run_cycle();
      check_val("srl", ALUResultM, 32'h1);
      ALUControlE = 3'd7; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
      run_cycle();
      check_val("slt_neg", ALUResultM, 32'h1);
      RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF;
      run_cycle();
      check_val("slt_pos", ALUResultM, 32'h0);

      // Store with forwarded data and base+imm address.
      clear_inputs();
      MemWriteE = 1'b1; ALUSrcE = 1'b1; ForwardBE = 2'd1; ResultW = 32'hDEAD_BEEF;
      RD1_E = 32'h1000; Imm_Ext_E = 32'h10; RD2_E = 32'h5;
      run_cycle();
      check_val("store_data", WriteDataM, 32'hDEAD_BEEF);
      check_val("store_addr", ALUResultM, 32'h1010);

      // Randomized traffic with occasional resets and forced equal operands.
      for (int i = 0; i < 300; i++) begin
         rst         = ($urandom_range(0, 19) == 0);
         RegWriteE   = $urandom_range(0, 1);
         ALUSrcE     = $urandom_range(0, 1);
         MemWriteE   = $urandom_range(0, 1);
         ResultSrcE  = $urandom_range(0, 1);
         BranchE     = $urandom_range(0, 1);
         ALUControlE = $urandom_range(0, 7);
         RD1_E       = $urandom;
         RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
         Imm_Ext_E   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 64) : $urandom;
         RD_E        = $urandom_range(0, 31);
         PCE         = $urandom;
         PCPlus4E    = PCE + 32'd4;
         ForwardAE   = $urandom_range(0, 3);
         ForwardBE   = $urandom_range(0, 3);
         ResultW     = $urandom;
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
